// File: rtl/timer_ctrl.sv
// Elapsed-seconds stopwatch controller with BCD digits and start/pause/stop.
// Ports: i_clk, i_rst_n (async low), i_start/i_pause/i_stop pulses,
//        o_ten/o_one BCD digits, o_tick pulse, o_state, o_done.
module timer_ctrl #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned MAX_SEC  = 99
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    output logic [3:0] o_ten,
    output logic [3:0] o_one,
    output logic       o_tick,
    output logic [1:0] o_state,
    output logic       o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Terminal digits are elaboration-time constants.
    localparam logic [31:0] LAST    = 32'(CLK_FREQ - 1);
    localparam logic [3:0]  MAX_TEN = 4'(MAX_SEC / 10);
    localparam logic [3:0]  MAX_ONE = 4'(MAX_SEC % 10);

    state_t      state;
    logic [31:0] presc;
    logic        wrap;
    logic [3:0]  nxt_ten;
    logic [3:0]  nxt_one;
    logic        hit_max;

    assign wrap = (presc == LAST);

    always_comb begin
        nxt_ten = o_ten;
        nxt_one = o_one + 4'd1;
        if (o_one == 4'd9) begin
            nxt_one = 4'd0;
            nxt_ten = o_ten + 4'd1;
        end
    end

    assign hit_max = (nxt_ten == MAX_TEN) && (nxt_one == MAX_ONE);
    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            presc  <= '0;
            o_ten  <= '0;
            o_one  <= '0;
            o_tick <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_tick <= 1'b0;
            if (i_stop) begin
                // Stop wins over everything, including a pending wrap.
                state  <= S_IDLE;
                presc  <= '0;
                o_ten  <= '0;
                o_one  <= '0;
                o_done <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            state <= S_RUN;
                            presc <= '0;
                            o_ten <= '0;
                            o_one <= '0;
                        end
                    end
                    S_RUN: begin
                        if (wrap) begin
                            // The increment commits even when pausing;
                            // reaching the terminal count beats pause.
                            presc  <= '0;
                            o_ten  <= nxt_ten;
                            o_one  <= nxt_one;
                            o_tick <= 1'b1;
                            if (hit_max) begin
                                state  <= S_DONE;
                                o_done <= 1'b1;
                            end else if (i_pause) begin
                                state <= S_PAUSE;
                            end
                        end else if (i_pause) begin
                            // Prescaler freezes at its current value.
                            state <= S_PAUSE;
                        end else begin
                            presc <= presc + 32'd1;
                        end
                    end
                    S_PAUSE: begin
                        if (i_start) begin
                            state <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        if (i_start) begin
                            state  <= S_RUN;
                            presc  <= '0;
                            o_ten  <= '0;
                            o_one  <= '0;
                            o_done <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with CLK_FREQ=4 and MAX_SEC=12.
// Table-driven vectors plus hand sequences for multi-cycle corners.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic       i_pause;
    logic       i_stop;
    logic [3:0] o_ten;
    logic [3:0] o_one;
    logic       o_tick;
    logic [1:0] o_state;
    logic       o_done;

    int passed = 0;
    int total  = 0;

    timer_ctrl #(
        .CLK_FREQ(4),
        .MAX_SEC (12)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_start(i_start),
        .i_pause(i_pause),
        .i_stop (i_stop),
        .o_ten  (o_ten),
        .o_one  (o_one),
        .o_tick (o_tick),
        .o_state(o_state),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       p;
        logic       t;
        logic [3:0] ten;
        logic [3:0] one;
        logic       tick;
        logic [1:0] st;
        logic       done;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic t);
        i_start = s;
        i_pause = p;
        i_stop  = t;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
    endtask

    task automatic expect_out(input string tag,
                              input int ten, input int one,
                              input int tick, input int st,
                              input int done);
        check({tag, " ten"},   32'(o_ten),   32'(ten));
        check({tag, " one"},   32'(o_one),   32'(one));
        check({tag, " tick"},  32'(o_tick),  32'(tick));
        check({tag, " state"}, 32'(o_state), 32'(st));
        check({tag, " done"},  32'(o_done),  32'(done));
    endtask

    task automatic set_vec(input int i, input logic s,
                           input logic p, input logic t,
                           input logic [3:0] ten,
                           input logic [3:0] one,
                           input logic tick, input logic [1:0] st,
                           input logic done);
        vecs[i].s    = s;
        vecs[i].p    = p;
        vecs[i].t    = t;
        vecs[i].ten  = ten;
        vecs[i].one  = one;
        vecs[i].tick = tick;
        vecs[i].st   = st;
        vecs[i].done = done;
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // start pulse, then first second, ignore rules, pause/resume,
        // pause+stop, stop+start.
        set_vec(0,  1, 0, 0, 0, 0, 0, 1, 0);
        set_vec(1,  0, 0, 0, 0, 0, 0, 1, 0);
        set_vec(2,  0, 0, 0, 0, 0, 0, 1, 0);
        set_vec(3,  0, 0, 0, 0, 0, 0, 1, 0);
        set_vec(4,  0, 0, 0, 0, 1, 1, 1, 0);
        set_vec(5,  1, 0, 0, 0, 1, 0, 1, 0);
        set_vec(6,  0, 1, 0, 0, 1, 0, 2, 0);
        set_vec(7,  0, 1, 0, 0, 1, 0, 2, 0);
        set_vec(8,  1, 0, 0, 0, 1, 0, 1, 0);
        set_vec(9,  0, 0, 0, 0, 1, 0, 1, 0);
        set_vec(10, 0, 0, 0, 0, 1, 0, 1, 0);
        set_vec(11, 0, 0, 0, 0, 2, 1, 1, 0);
        set_vec(12, 0, 0, 0, 0, 2, 0, 1, 0);
        set_vec(13, 0, 1, 1, 0, 0, 0, 0, 0);
        set_vec(14, 0, 1, 0, 0, 0, 0, 0, 0);
        set_vec(15, 1, 0, 0, 0, 0, 0, 1, 0);
        set_vec(16, 1, 0, 1, 0, 0, 0, 0, 0);
        set_vec(17, 1, 0, 0, 0, 0, 0, 1, 0);

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
        #12;
        expect_out("reset", 0, 0, 0, 0, 0);
        check("reset presc", dut.presc, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].s, vecs[i].p, vecs[i].t);
            expect_out($sformatf("vec%0d", i),
                       vecs[i].ten, vecs[i].one, vecs[i].tick,
                       vecs[i].st, vecs[i].done);
        end

        // Run from 00 to terminal 12, then hold.
        for (int c = 1; c <= 60; c++) begin
            int sec;
            int tk;
            int st;
            step(1'b0, 1'b0, 1'b0);
            sec = (c / 4 > 12) ? 12 : c / 4;
            tk  = (c % 4 == 0 && c <= 48) ? 1 : 0;
            st  = (c >= 48) ? 3 : 1;
            expect_out($sformatf("run c%0d", c),
                       sec / 10, sec % 10, tk, st,
                       (c >= 48) ? 1 : 0);
        end

        // Restart from DONE clears the digits.
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart", 0, 0, 0, 1, 0);
        check("restart presc", dut.presc, 32'd0);

        // Pause at prescaler 2, hold 10 cycles, resume.
        run_idle(2);
        step(1'b0, 1'b1, 1'b0);
        check("pause presc", dut.presc, 32'd2);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            expect_out($sformatf("hold%0d", k), 0, 0, 0, 2, 0);
        end
        step(1'b1, 1'b0, 1'b0);
        expect_out("resume", 0, 0, 0, 1, 0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("resume+1", 0, 0, 0, 1, 0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("resume+2", 0, 1, 1, 1, 0);

        // Pause coincident with the wrap from 03 to 04.
        run_idle(8);
        expect_out("at03", 0, 3, 1, 1, 0);
        run_idle(3);
        step(1'b0, 1'b1, 1'b0);
        expect_out("pwrap", 0, 4, 1, 2, 0);
        check("pwrap presc", dut.presc, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("pwrap+1", 0, 4, 0, 2, 0);
        step(1'b1, 1'b0, 1'b0);
        run_idle(3);
        expect_out("pres3", 0, 4, 0, 1, 0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("pres4", 0, 5, 1, 1, 0);

        // Stop coincident with a wrap suppresses the tick.
        run_idle(3);
        step(1'b0, 1'b0, 1'b1);
        expect_out("swrap", 0, 0, 0, 0, 0);

        // Pause on the wrap reaching 12 enters DONE.
        step(1'b1, 1'b0, 1'b0);
        run_idle(44);
        expect_out("at11", 1, 1, 1, 1, 0);
        run_idle(3);
        step(1'b0, 1'b1, 1'b0);
        expect_out("pmax", 1, 2, 1, 3, 1);
        step(1'b0, 1'b1, 1'b0);
        expect_out("pmax+1", 1, 2, 0, 3, 1);

        // Async reset mid-run at 07.
        step(1'b1, 1'b0, 1'b0);
        run_idle(28);
        expect_out("at07", 0, 7, 1, 1, 0);
        run_idle(2);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("midrst", 0, 0, 0, 0, 0);
        check("midrst presc", dut.presc, 32'd0);
        #2;
        rst_n = 1'b1;
        run_idle(8);
        expect_out("postrst", 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        run_idle(4);
        expect_out("postrst run", 0, 1, 1, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning clock cycles per elapsed second (legal 2..2^32-1).
REQ-002 The block SHALL have parameter MAX_SEC, default 99, meaning the terminal seconds count (legal 1..99).
REQ-003 The block SHALL have port i_clk, input, 1, meaning the system clock; all state on rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1, meaning reset (asynchronous, active-low).
REQ-005 The block SHALL have port i_start, input, 1, meaning a one-cycle start/resume pulse.
REQ-006 The block SHALL have port i_pause, input, 1, meaning a one-cycle pause pulse.
REQ-007 The block SHALL have port i_stop, input, 1, meaning a one-cycle stop/clear pulse.
REQ-008 The block SHALL have port o_ten, output, 4, meaning the BCD tens digit of elapsed seconds (registered).
REQ-009 The block SHALL have port o_one, output, 4, meaning the BCD ones digit of elapsed seconds (registered).
REQ-010 The block SHALL have port o_tick, output, 1, meaning a one-cycle pulse in the cycle the seconds value increments.
REQ-011 The block SHALL have port o_state, output, 2, meaning FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
REQ-012 The block SHALL have port o_done, output, 1, meaning high exactly while state is DONE.

Function
REQ-013 The block SHALL hold a 32-bit prescaler that counts 0..CLK_FREQ-1 only in RUN and is frozen in PAUSE.
REQ-014 The block SHALL, in RUN with prescaler at CLK_FREQ-1, load prescaler 0, increment seconds and assert o_tick for that cycle's output (o_tick registered, high the cycle after the edge, seconds updated on the same edge).
REQ-015 The block SHALL keep seconds as two BCD digits; ones 9 -> 0 with tens +1; no binary divide/modulo.
REQ-016 The block SHALL enter DONE on the increment that makes seconds equal MAX_SEC; digits hold at MAX_SEC, prescaler cleared.
REQ-017 The block SHALL apply command priority stop > pause > start when pulses coincide.
REQ-018 IDLE: start -> RUN with seconds and prescaler cleared; pause ignored.
REQ-019 RUN: pause -> PAUSE; start ignored.
REQ-020 PAUSE: start -> RUN resuming from the frozen prescaler and seconds; pause ignored.
REQ-021 DONE: start -> RUN with seconds and prescaler cleared; pause ignored.
REQ-022 Any state: stop -> IDLE with seconds 00 and prescaler 0 on the next edge.
REQ-023 A pause arriving in the same cycle as a prescaler wrap SHALL commit the increment (and o_tick) and then enter PAUSE with prescaler 0.
REQ-024 A stop arriving in the same cycle as a wrap SHALL suppress the increment and o_tick.
REQ-025 A wrap reaching MAX_SEC coincident with pause SHALL enter DONE, not PAUSE.
REQ-026 o_tick SHALL never be high outside RUN-to-RUN/PAUSE/DONE transitions defined above, and never two consecutive cycles.

Reset
REQ-027 On i_rst_n low, asynchronously: state IDLE, prescaler 0, o_ten 0, o_one 0, o_tick 0, o_done 0.
REQ-028 Reset asserted mid-RUN SHALL discard all progress; release returns to IDLE awaiting start.
REQ-029 Inputs SHALL be ignored on the first edge after reset release only if coincident with release; no other synchronizer is inside the block.

Verification (CLK_FREQ=4, MAX_SEC=12)
REQ-030 Start pulse, run 20 cycles -> o_tick every 4 cycles, digits 0,1,...,5; o_state=1.
REQ-031 Run to 09 then 4 more cycles -> o_ten=1, o_one=0; after 12 s o_done=1, o_state=3, digits hold 1/2, no further ticks.
REQ-032 Pause at prescaler 2, wait 10 cycles, start -> digits unchanged during pause; next tick exactly 2 cycles after resume.
REQ-033 Pause and stop same cycle in RUN -> o_state=0, digits 00, no tick.
REQ-034 Pause coincident with wrap at 03 -> o_tick=1 once, digits 04, o_state=2, prescaler 0.
REQ-035 Assert i_rst_n low mid-RUN at 07 between clock edges -> outputs zero immediately; after release, no counting until start.
